mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- MEM-stage consumer of the EX/MEM pipeline register outputs.
- Resolves the branch decision and drives a data memory over a req/ready handshake that may take several cycles.
- Stalls the upstream pipeline while an access is outstanding, then loads the MEM/WB register contents.
- Includes a timeout watchdog so a memory that never answers cannot hang the pipeline.

Parameters:
- B, 32, data/address width.
- TIMEOUT, 16, maximum ACCESS cycles before abort (≥2); counter width clog2(TIMEOUT)+1.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- add_result_in  in  B  branch target from EX/MEM.
- alu_result_in  in  B  ALU result / memory byte address.
- r_data2_in  in  B  store data.
- mux_RegDst_in  in  B  destination register index.
- zero_in  in  1  ALU zero flag.
- wb_RegWrite_in, wb_MemtoReg_in  in  1 each  WB controls.
- m_Branch_in, m_MemRead_in, m_MemWrite_in  in  1 each  MEM controls.
- dmem_req  out  1  registered request.
- dmem_we  out  1  registered write enable.
- dmem_addr  out  B  registered address.
- dmem_wdata  out  B  registered store data.
- dmem_rdata  in  B  read data, valid when dmem_ready=1.
- dmem_ready  in  1  access complete.
- pc_src  out  1  take branch.
- branch_target  out  B  equals add_result_in.
- stall  out  1  freeze IF/ID/EX and the EX/MEM latch.
- mem_error  out  1  sticky timeout flag.
- read_data_out, alu_result_out, reg_dst_out  out  B each  MEM/WB data.
- wb_RegWrite_out, wb_MemtoReg_out  out  1 each  MEM/WB controls.

Behaviour:
- States are IDLE, ACCESS and ABORT. Reset forces IDLE and clears every registered output, dmem_*, mem_error and the counter to 0.
- Reset is asynchronous. Asserting it mid-ACCESS drops dmem_req immediately and discards the access.
- memop = m_MemRead_in | m_MemWrite_in.
- IDLE, memop=0:
  - stall=0.
  - Next edge: alu_result_out<=alu_result_in, reg_dst_out<=mux_RegDst_in, WB controls<=inputs, read_data_out holds.
- IDLE, memop=1:
  - stall=1 combinationally.
  - Next edge: enter ACCESS; dmem_req<=1, dmem_we<=m_MemWrite_in, dmem_addr<=alu_result_in, dmem_wdata<=r_data2_in, counter<=0.
  - MEM/WB loads a bubble: wb_RegWrite_out<=0, wb_MemtoReg_out<=0, data outputs hold.
- Read and write asserted together: the write wins (dmem_we=1) and read_data_out is not updated.
- ACCESS:
  - dmem_req, dmem_we, dmem_addr and dmem_wdata are held stable.
  - stall = !dmem_ready.
  - dmem_ready=0: counter++ and MEM/WB loads a bubble.
  - dmem_ready=1 at an edge: read_data_out<=dmem_rdata if a read; alu_result_out, reg_dst_out and WB controls <= current inputs; dmem_req<=0, dmem_we<=0; go to IDLE.
  - Minimum memory-op latency is 2 cycles (the IDLE cycle plus one ACCESS cycle).
- Timeout: in ACCESS with counter==TIMEOUT-1 and dmem_ready=0, the next edge goes to ABORT with dmem_req<=0 and mem_error<=1.
- dmem_ready on the same edge as the timeout: ready wins, the access completes normally and no error is raised.
- ABORT (one cycle):
  - stall=0.
  - MEM/WB loads a bubble, so the faulting instruction retires with no register write.
  - Next state is IDLE.
  - mem_error stays 1 until reset.
- Branch:
  - pc_src = m_Branch_in & zero_in & (state==IDLE) & !memop, combinational.
  - branch_target = add_result_in, combinational.
  - Branch and memory op together is illegal; the memory op takes precedence and pc_src=0.
- dmem_ready while in IDLE or ABORT is ignored.
- Address is passed through unmodified at full B width; no alignment check.

Test Plan:
- Reset asserted mid-ACCESS with dmem_req=1 -> dmem_req, stall and all MEM/WB outputs read 0 the same cycle; state IDLE after release.
- ALU op (alu_result_in=0x0000_0010, RegDst=5, RegWrite=1, no memop) -> stall=0; next edge alu_result_out=0x10, reg_dst_out=5, wb_RegWrite_out=1.
- Load addr 0x40, memory answers ready after 3 ACCESS cycles with rdata=0xDEADBEEF:
  - stall=1 for 4 cycles;
  - dmem_addr=0x40 and dmem_we=0 held;
  - read_data_out=0xDEADBEEF with wb_MemtoReg_out=1 after completion;
  - bubbles (RegWrite=0) during the stall.
- Store addr 0x80, data 0x1234, ready on first ACCESS cycle -> dmem_we=1, dmem_wdata=0x1234, total stall 1 cycle, read_data_out unchanged.
- Branch with zero_in=1 in IDLE -> pc_src=1, branch_target=add_result_in; zero_in=0 -> pc_src=0.
- Load with ready never asserted, TIMEOUT=16 -> ABORT after 16 ACCESS cycles, dmem_req=0, mem_error=1 sticky, wb_RegWrite_out=0; repeat with ready on cycle 16 -> normal completion, mem_error=0.

Source files
------------

// File: rtl/mem_access_unit.sv
// ============================================================================
// mem_access_unit
// MEM-stage unit: resolves branches, drives a data memory over a req/ready
// handshake, stalls the pipeline while an access is outstanding and loads
// the MEM/WB register. A watchdog aborts accesses that never complete.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_access_unit #(
   parameter int B       = 32,
   parameter int TIMEOUT = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [B-1:0] add_result_in,
   input  logic [B-1:0] alu_result_in,
   input  logic [B-1:0] r_data2_in,
   input  logic [B-1:0] mux_RegDst_in,
   input  logic         zero_in,
   input  logic         wb_RegWrite_in,
   input  logic         wb_MemtoReg_in,
   input  logic         m_Branch_in,
   input  logic         m_MemRead_in,
   input  logic         m_MemWrite_in,
   output logic         dmem_req,
   output logic         dmem_we,
   output logic [B-1:0] dmem_addr,
   output logic [B-1:0] dmem_wdata,
   input  logic [B-1:0] dmem_rdata,
   input  logic         dmem_ready,
   output logic         pc_src,
   output logic [B-1:0] branch_target,
   output logic         stall,
   output logic         mem_error,
   output logic [B-1:0] read_data_out,
   output logic [B-1:0] alu_result_out,
   output logic [B-1:0] reg_dst_out,
   output logic         wb_RegWrite_out,
   output logic         wb_MemtoReg_out
);

   localparam int            CW         = $clog2(TIMEOUT) + 1;
   localparam logic [CW-1:0] LAST_COUNT = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      ABORT  = 2'd2
   } state_t;

   state_t        state;
   logic [CW-1:0] count;
   logic          memop;

   assign memop         = m_MemRead_in | m_MemWrite_in;
   assign branch_target = add_result_in;
   // A memory op in the same slot as a branch suppresses the branch.
   assign pc_src        = m_Branch_in & zero_in & (state == IDLE) & ~memop;

   // Stall while a memory op is being launched or is still waiting for ready;
   // held low during reset so the pipeline is released immediately.
   always_comb begin
      stall = 1'b0;
      if (!reset) begin
         case (state)
            IDLE:    stall = memop;
            ACCESS:  stall = ~dmem_ready;
            default: stall = 1'b0;
         endcase
      end
   end

   // Access sequencer: memory handshake, watchdog and MEM/WB register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state           <= IDLE;
         count           <= '0;
         dmem_req        <= 1'b0;
         dmem_we         <= 1'b0;
         dmem_addr       <= '0;
         dmem_wdata      <= '0;
         mem_error       <= 1'b0;
         read_data_out   <= '0;
         alu_result_out  <= '0;
         reg_dst_out     <= '0;
         wb_RegWrite_out <= 1'b0;
         wb_MemtoReg_out <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (memop) begin
                  // Launch the access; write wins when both are requested.
                  state           <= ACCESS;
                  dmem_req        <= 1'b1;
                  dmem_we         <= m_MemWrite_in;
                  dmem_addr       <= alu_result_in;
                  dmem_wdata      <= r_data2_in;
                  count           <= '0;
                  wb_RegWrite_out <= 1'b0;
                  wb_MemtoReg_out <= 1'b0;
               end else begin
                  alu_result_out  <= alu_result_in;
                  reg_dst_out     <= mux_RegDst_in;
                  wb_RegWrite_out <= wb_RegWrite_in;
                  wb_MemtoReg_out <= wb_MemtoReg_in;
               end
            end
            ACCESS: begin
               if (dmem_ready) begin
                  // Completion takes priority over the watchdog.
                  if (!dmem_we) begin
                     read_data_out <= dmem_rdata;
                  end
                  alu_result_out  <= alu_result_in;
                  reg_dst_out     <= mux_RegDst_in;
                  wb_RegWrite_out <= wb_RegWrite_in;
                  wb_MemtoReg_out <= wb_MemtoReg_in;
                  dmem_req        <= 1'b0;
                  dmem_we         <= 1'b0;
                  state           <= IDLE;
               end else if (count == LAST_COUNT) begin
                  dmem_req        <= 1'b0;
                  dmem_we         <= 1'b0;
                  mem_error       <= 1'b1;
                  wb_RegWrite_out <= 1'b0;
                  wb_MemtoReg_out <= 1'b0;
                  state           <= ABORT;
               end else begin
                  count           <= count + 1'b1;
                  wb_RegWrite_out <= 1'b0;
                  wb_MemtoReg_out <= 1'b0;
               end
            end
            ABORT: begin
               // Faulting instruction retires without a register write.
               wb_RegWrite_out <= 1'b0;
               wb_MemtoReg_out <= 1'b0;
               state           <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// ============================================================================
// tb_mem_access_unit
// Scoreboard bench: a driver issues instructions and models the memory, an
// instruction-level reference model predicts each retirement, and a monitor
// compares the MEM/WB register whenever the pipeline advances.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_access_unit;

   localparam int B       = 32;
   localparam int TIMEOUT = 16;

   logic         clk = 1'b0;
   logic         reset;
   logic [B-1:0] add_result_in, alu_result_in, r_data2_in, mux_RegDst_in;
   logic         zero_in, wb_RegWrite_in, wb_MemtoReg_in;
   logic         m_Branch_in, m_MemRead_in, m_MemWrite_in;
   logic         dmem_req, dmem_we;
   logic [B-1:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic         dmem_ready;
   logic         pc_src, stall, mem_error;
   logic [B-1:0] branch_target, read_data_out, alu_result_out, reg_dst_out;
   logic         wb_RegWrite_out, wb_MemtoReg_out;

   mem_access_unit #(.B(B), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset),
      .add_result_in(add_result_in), .alu_result_in(alu_result_in),
      .r_data2_in(r_data2_in), .mux_RegDst_in(mux_RegDst_in),
      .zero_in(zero_in), .wb_RegWrite_in(wb_RegWrite_in),
      .wb_MemtoReg_in(wb_MemtoReg_in), .m_Branch_in(m_Branch_in),
      .m_MemRead_in(m_MemRead_in), .m_MemWrite_in(m_MemWrite_in),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
      .pc_src(pc_src), .branch_target(branch_target), .stall(stall),
      .mem_error(mem_error), .read_data_out(read_data_out),
      .alu_result_out(alu_result_out), .reg_dst_out(reg_dst_out),
      .wb_RegWrite_out(wb_RegWrite_out), .wb_MemtoReg_out(wb_MemtoReg_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [B-1:0] rd, alu, dst;
      logic         rw, mt, err;
      int           stalls;
   } exp_t;

   exp_t exp_q[$];
   exp_t model;           // architectural MEM/WB state after the last issued instruction
   int   n_checks = 0;
   int   n_pass   = 0;
   bit   sb_en    = 1'b0;

   task automatic chk(input bit ok, input string name,
                      input logic [127:0] act, input logic [127:0] req);
      n_checks++;
      if (ok) n_pass++;
      else $display("FAIL %s: actual=%h required=%h", name, act, req);
   endtask

   // Monitor: every edge at which stall was low retires one instruction.
   exp_t last = '{rd: '0, alu: '0, dst: '0, rw: 1'b0, mt: 1'b0, err: 1'b0, stalls: 0};
   int   stall_cnt = 0;
   always begin : monitor
      bit st, active;
      exp_t e;
      @(negedge clk);
      #2;
      st     = stall;
      active = sb_en;
      @(posedge clk);
      #1;
      if (active) begin
         if (st) begin
            stall_cnt++;
            chk({read_data_out, alu_result_out, reg_dst_out, wb_RegWrite_out, wb_MemtoReg_out}
                == {last.rd, last.alu, last.dst, 2'b00}, "bubble",
                {read_data_out, alu_result_out, reg_dst_out, wb_RegWrite_out, wb_MemtoReg_out},
                {last.rd, last.alu, last.dst, 2'b00});
         end else if (exp_q.size() == 0) begin
            chk(1'b0, "unexpected_retire", 128'd1, 128'd0);
         end else begin
            e = exp_q.pop_front();
            chk({read_data_out, alu_result_out, reg_dst_out, wb_RegWrite_out,
                 wb_MemtoReg_out, mem_error} == {e.rd, e.alu, e.dst, e.rw, e.mt, e.err},
                "retire",
                {read_data_out, alu_result_out, reg_dst_out, wb_RegWrite_out,
                 wb_MemtoReg_out, mem_error},
                {e.rd, e.alu, e.dst, e.rw, e.mt, e.err});
            chk(stall_cnt == e.stalls, "stall_cycles", 128'(stall_cnt), 128'(e.stalls));
            last      = e;
            stall_cnt = 0;
         end
      end
   end

   // Issue one instruction, play the memory with the given latency (number of
   // ACCESS cycles without ready), and return right after it leaves the stage.
   task automatic run_instr(input logic [B-1:0] add, input logic [B-1:0] alu,
                            input logic [B-1:0] d2, input logic [B-1:0] dst,
                            input logic z, input logic rw, input logic mt,
                            input logic br, input logic mr, input logic mw,
                            input int lat, input logic [B-1:0] rdata);
      logic memop;
      bit   done, s;
      int   acc, cyc, exp_acc;
      memop = mr | mw;
      if (!memop) begin
         model.alu = alu; model.dst = dst; model.rw = rw; model.mt = mt;
         model.stalls = 0;
         exp_acc = 0;
      end else if (lat < TIMEOUT) begin
         if (!mw) model.rd = rdata;
         model.alu = alu; model.dst = dst; model.rw = rw; model.mt = mt;
         model.stalls = lat + 1;
         exp_acc = lat + 1;
      end else begin
         model.rw = 1'b0; model.mt = 1'b0; model.err = 1'b1;
         model.stalls = TIMEOUT + 1;
         exp_acc = TIMEOUT;
      end
      exp_q.push_back(model);

      add_result_in = add; alu_result_in = alu; r_data2_in = d2; mux_RegDst_in = dst;
      zero_in = z; wb_RegWrite_in = rw; wb_MemtoReg_in = mt;
      m_Branch_in = br; m_MemRead_in = mr; m_MemWrite_in = mw;

      acc = 0; cyc = 0; done = 1'b0;
      while (!done && cyc < 4 * TIMEOUT) begin
         @(negedge clk);
         if (dmem_req) begin
            acc++;
            chk({dmem_we, dmem_addr, dmem_wdata} == {mw, alu, d2}, "dmem_hold",
                {dmem_we, dmem_addr, dmem_wdata}, {mw, alu, d2});
            dmem_ready = (acc == lat + 1);
            dmem_rdata = (acc == lat + 1) ? rdata : B'($urandom);
         end else begin
            dmem_ready = 1'($urandom_range(0, 1));   // must be ignored outside ACCESS
            dmem_rdata = B'($urandom);
         end
         #1;
         chk({pc_src, branch_target} == {br & z & ~memop, add}, "branch",
             {pc_src, branch_target}, {br & z & ~memop, add});
         s = stall;
         @(posedge clk);
         #1;
         dmem_ready = 1'b0;
         cyc++;
         if (!s) done = 1'b1;
      end
      if (!done) begin
         $display("FAIL instr_timeout: actual=stalled required=retire after %0d cycles", cyc);
         $fatal(1, "pipeline hung");
      end
      chk(acc == exp_acc, "access_cycles", 128'(acc), 128'(exp_acc));
   endtask

   task automatic zero_inputs();
      add_result_in = '0; alu_result_in = '0; r_data2_in = '0; mux_RegDst_in = '0;
      zero_in = 1'b0; wb_RegWrite_in = 1'b0; wb_MemtoReg_in = 1'b0;
      m_Branch_in = 1'b0; m_MemRead_in = 1'b0; m_MemWrite_in = 1'b0;
      dmem_rdata = '0; dmem_ready = 1'b0;
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL global_timeout: actual=running required=finished");
      $fatal(1, "global timeout");
   end

   initial begin : driver
      bit seen;
      logic [B-1:0] o_all;
      reset = 1'b1;
      zero_inputs();
      model = '{rd: '0, alu: '0, dst: '0, rw: 1'b0, mt: 1'b0, err: 1'b0, stalls: 0};

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      o_all = read_data_out | alu_result_out | reg_dst_out | dmem_addr | dmem_wdata;
      chk({dmem_req, dmem_we, stall, mem_error, wb_RegWrite_out, wb_MemtoReg_out, o_all} == '0,
          "reset_state",
          {dmem_req, dmem_we, stall, mem_error, wb_RegWrite_out, wb_MemtoReg_out, o_all}, 128'd0);
      @(negedge clk);
      reset = 1'b0;

      // Reset asserted in the middle of an access
      @(posedge clk);
      #1;
      alu_result_in = 32'h40; m_MemRead_in = 1'b1; wb_RegWrite_in = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 6 && !seen; i++) begin
         @(negedge clk);
         seen = dmem_req;
      end
      chk(seen, "req_before_reset", 128'(seen), 128'd1);
      #2;
      reset = 1'b1;
      #1;
      o_all = read_data_out | alu_result_out | reg_dst_out;
      chk({dmem_req, stall, wb_RegWrite_out, wb_MemtoReg_out, o_all} == '0, "async_reset",
          {dmem_req, stall, wb_RegWrite_out, wb_MemtoReg_out, o_all}, 128'd0);
      @(negedge clk);
      zero_inputs();
      reset = 1'b0;
      @(posedge clk);
      #1;
      chk({dmem_req, stall} == 2'b00, "post_reset_idle", {dmem_req, stall}, 128'd0);

      // Directed instruction stream
      sb_en = 1'b1;
      run_instr(32'h0, 32'h10, 32'h0, 32'd5, 0, 1, 0, 0, 0, 0, 0, 32'h0);            // ALU op
      run_instr(32'h0, 32'h40, 32'h0, 32'd7, 0, 1, 1, 0, 1, 0, 3, 32'hDEADBEEF);     // load, 3 waits
      run_instr(32'h0, 32'h80, 32'h1234, 32'd0, 0, 0, 0, 0, 0, 1, 0, 32'hFFFF0000);  // store, no wait
      run_instr(32'h1000, 32'h3, 32'h0, 32'd2, 1, 0, 0, 1, 0, 0, 0, 32'h0);         // branch taken
      run_instr(32'h2000, 32'h4, 32'h0, 32'd3, 0, 0, 0, 1, 0, 0, 0, 32'h0);         // branch not taken
      run_instr(32'h3000, 32'h44, 32'h9, 32'd8, 1, 1, 1, 1, 1, 0, 1, 32'hCAFE0001); // branch + load
      run_instr(32'h0, 32'h48, 32'h0, 32'd9, 0, 1, 1, 0, 1, 0, TIMEOUT - 1, 32'h0BADF00D); // ready on last cycle
      run_instr(32'h0, 32'hC0, 32'h5, 32'd4, 0, 1, 1, 0, 1, 1, 0, 32'h11111111);    // read+write: write wins
      run_instr(32'h0, 32'h4C, 32'h0, 32'd10, 0, 1, 1, 0, 1, 0, 1000, 32'h0);       // never ready: abort

      // Randomized stream
      for (int n = 0; n < 60; n++) begin
         int k, r, lat;
         logic mr, mw;
         k  = int'($urandom_range(0, 9));
         mr = (k >= 4 && k <= 6) || k == 9;
         mw = (k >= 7);
         r  = int'($urandom_range(0, 9));
         lat = (r < 8) ? r : ((r == 8) ? TIMEOUT - 1 : TIMEOUT + 3);
         run_instr(B'($urandom), B'($urandom), B'($urandom), B'($urandom_range(0, 31)),
                   1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), mr, mw,
                   lat, B'($urandom));
      end
      sb_en = 1'b0;
      zero_inputs();
      repeat (3) @(posedge clk);
      #1;
      chk(exp_q.size() == 0, "queue_drain", 128'(exp_q.size()), 128'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
